flash_port_arbiter: RTL
=======================

// Module: flash_port_arbiter
// PURPOSE
//  Shares the single instruction-flash read port between the fetch path (IF) and the load/literal path (LS).
//  Sequences the flash handshake: ld pulse, wait on busy, capture dout.
//  Returns data to the winning requester with a one-cycle valid.
//  Sits between the core's fetch/load logic and the flash controller.
// PARAMETERS
//  ADDR_W       10  flash word-address width
//  DATA_W       32  flash data width
//  STARVE_MAX   4   consecutive IF losses (while requesting) before IF is forced to win
//  TIMEOUT_CYC  64  WAIT cycles before abort (only with FLASH_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous, active-low reset
//  if_req      in   1       fetch request; hold with if_addr stable until if_gnt
//  if_addr     in   ADDR_W  fetch word address
//  if_gnt      out  1       1-cycle pulse: IF request accepted
//  if_rvalid   out  1       1-cycle pulse: if_rdata valid
//  ls_req      in   1       load request; same rules as if_req
//  ls_addr     in   ADDR_W  load word address
//  ls_gnt      out  1       1-cycle pulse: LS request accepted
//  ls_rvalid   out  1       1-cycle pulse: ls_rdata valid
//  rdata       out  DATA_W  shared registered read data, held until next capture
//  flash_ld    out  1       1-cycle read strobe to flash
//  flash_addr  out  ADDR_W  registered address, stable from ISSUE until next ISSUE
//  flash_busy  in   1       flash not ready; dout invalid while high
//  flash_dout  in   DATA_W  flash read data
//  flash_err   out  1       1-cycle pulse on timeout abort (tied 0 without macro)
// BEHAVIOUR
//  - Reset (rst=0 at an edge):
//    - state=IDLE; all outputs 0; starve counter 0.
//    - An in-flight access is dropped: no rvalid is produced for it.
//  - FSM states: IDLE, ISSUE, WAIT, DONE.
//  - Arbitration happens only in IDLE and DONE, and only when flash_busy=0 and a req is high.
//    - Winner's addr is latched into flash_addr; owner is registered; next state is ISSUE.
//    - Otherwise DONE goes to IDLE, and IDLE stays in IDLE.
//  - Priority:
//    - LS beats IF.
//    - Exception: when starve counter == STARVE_MAX, IF wins.
//    - Starve counter increments when IF requests and loses.
//    - Starve counter clears when IF is granted or if_req=0 at arbitration.
//    - Counter saturates at STARVE_MAX.
//  - ISSUE (1 cycle): flash_ld=1 and owner gnt=1, both registered outputs. Next state WAIT.
//  - WAIT:
//    - If flash_busy=0: rdata<=flash_dout, next state DONE.
//    - Else stay in WAIT. Flash must raise busy in the cycle after flash_ld if it needs more time.
//  - DONE: owner rvalid=1 for exactly 1 cycle; may arbitrate again in the same cycle.
//  - req is ignored in ISSUE and WAIT.
//    - A requester must drop req the cycle after gnt unless it has a new access.
//    - A req still high in DONE is treated as a new request.
//  - Latency with zero-wait flash: req seen in IDLE at cycle 0 -> gnt/flash_ld at 1 -> capture at 2 -> rvalid at 3.
//  - Back-to-back throughput: DONE->ISSUE gives one access per 3 cycles.
//  - Never more than one gnt, rvalid, or flash_ld high in any cycle.
//  - gnt and rvalid only go to the registered owner.
// CONFIGURATION
//  FLASH_TIMEOUT_EN defined:
//  - A counter runs in WAIT.
//  - If busy is still high after TIMEOUT_CYC WAIT cycles: go to DONE with rdata=0, owner rvalid=1, flash_err=1.
//  - The next issue is still blocked until flash_busy=0.
//  FLASH_TIMEOUT_EN undefined:
//  - WAIT lasts indefinitely; flash_err is constant 0; no counter logic.
// TESTING
//  1. IF-only, if_addr=0x004, flash_busy=0, flash_dout=0xDEADBEEF:
//     if_gnt and flash_ld at cycle 1 with flash_addr=0x004; if_rvalid at cycle 3 with rdata=0xDEADBEEF; ls_* outputs stay 0.
//  2. if_req and ls_req both rise in IDLE, ls_addr=0x010, if_addr=0x020:
//     LS served first (flash_addr=0x010, ls_rvalid); IF issued from DONE next (flash_addr=0x020, if_rvalid).
//  3. ls_req held high continuously with IF requesting:
//     IF is granted after exactly STARVE_MAX=4 LS grants; starve counter then clears.
//  4. flash_busy held high 5 cycles after flash_ld, dout=0x12345678:
//     rvalid 1 cycle after busy falls with rdata=0x12345678; no new flash_ld while busy is high.
//  5. rst=0 asserted during WAIT:
//     next cycle all outputs 0 and state IDLE; no rvalid for the aborted access; a new req is served normally afterwards.
//  6. FLASH_TIMEOUT_EN defined, busy stuck high:
//     after 64 WAIT cycles, flash_err=1 and rvalid=1 with rdata=0; no flash_ld until busy=0.
//     Macro undefined: stays in WAIT and flash_err stays 0.

Source files
------------

// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: shares the instruction-flash read port between fetch (IF) and load (LS) requesters.
// Optional FLASH_TIMEOUT_EN aborts a WAIT stuck on flash_busy after TIMEOUT_CYC cycles.
module flash_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              flash_ld,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_busy,
  input  logic [DATA_W-1:0] flash_dout,
  output logic              flash_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic flash_ld_q, flash_ld_d;
  logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic arb, if_win;
`ifdef FLASH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_q, tmo_d;
  logic flash_err_q, flash_err_d;
  assign flash_err = flash_err_q;
`else
  assign flash_err = 1'b0;
`endif
  assign if_gnt     = if_gnt_q;
  assign ls_gnt     = ls_gnt_q;
  assign if_rvalid  = if_rvalid_q;
  assign ls_rvalid  = ls_rvalid_q;
  assign flash_ld   = flash_ld_q;
  assign flash_addr = flash_addr_q;
  assign rdata      = rdata_q;
  always_comb begin
    arb          = (state_q == IDLE || state_q == DONE) && !flash_busy && (if_req || ls_req);
    if_win       = if_req && (!ls_req || starve_q == SW'(STARVE_MAX));
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    flash_addr_d = flash_addr_q;
    rdata_d      = rdata_q;
    if_gnt_d     = 1'b0;
    ls_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    ls_rvalid_d  = 1'b0;
    flash_ld_d   = 1'b0;
`ifdef FLASH_TIMEOUT_EN
    tmo_d        = (state_q == WAIT) ? tmo_q + TW'(1) : '0;
    flash_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (arb) begin
          state_d      = ISSUE;
          owner_d      = !if_win;
          flash_addr_d = if_win ? if_addr : ls_addr;
          if_gnt_d     = if_win;
          ls_gnt_d     = !if_win;
          flash_ld_d   = 1'b1;
          starve_d     = (if_win || !if_req) ? '0 :
                         (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!flash_busy) begin
          state_d     = DONE;
          rdata_d     = flash_dout;
          if_rvalid_d = !owner_q;
          ls_rvalid_d = owner_q;
        end
`ifdef FLASH_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d     = DONE;
          rdata_d     = '0;
          if_rvalid_d = !owner_q;
          ls_rvalid_d = owner_q;
          flash_err_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_q     <= '0;
      if_gnt_q     <= 1'b0;
      ls_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      flash_ld_q   <= 1'b0;
      flash_addr_q <= '0;
      rdata_q      <= '0;
`ifdef FLASH_TIMEOUT_EN
      tmo_q        <= '0;
      flash_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      if_gnt_q     <= if_gnt_d;
      ls_gnt_q     <= ls_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      ls_rvalid_q  <= ls_rvalid_d;
      flash_ld_q   <= flash_ld_d;
      flash_addr_q <= flash_addr_d;
      rdata_q      <= rdata_d;
`ifdef FLASH_TIMEOUT_EN
      tmo_q        <= tmo_d;
      flash_err_q  <= flash_err_d;
`endif
    end
  end
endmodule
